// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported synchronous word RAM between three requesters:
// the cpu instruction port, the cpu data port and a host loader port that
// writes program images. Data requests beat instruction requests. A streak
// counter caps how many data grants in a row can be given while an
// instruction request waits. Raising ld_mode halts the cpu. After a one-cycle
// drain the host gets the RAM to itself.
//
// Handshake (all three ports): a requester raises req and holds req, addr and
// write data stable until it sees gnt high in the same cycle. gnt is
// combinational from req and registered state. At most one gnt is high per
// cycle, and mem_* mirror the granted requester. Read data arrives one cycle
// after a read grant, qualified by that port's registered rvalid. Writes
// return no rvalid.
//
// Parameters
//   AW          RAM word-address width (depth 2**AW words)
//   STREAK_MAX  max consecutive data grants while i_req waits (>= 1)
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cpu_halt                  1 while in DRAIN/LOAD: cpu must not advance
//   i_req/i_addr/i_gnt        instruction read request
//   i_rvalid/i_rdata          instruction read response
//   d_req/d_addr/d_we/d_wdata data request (d_we == 0 means read)
//   d_gnt/d_rvalid/d_rdata    data grant and read response
//   ld_mode                   level: host wants exclusive RAM access
//   ld_req/ld_addr/ld_wdata   loader full-word write request
//   ld_gnt                    loader write accepted
//   mem_en/mem_addr/mem_we/mem_wdata/mem_rdata   RAM port
//   dbg_state                 current FSM state (RUN=0, DRAIN=1, LOAD=2)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW         = 12,
  parameter int STREAK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic          cpu_halt,
  // instruction port
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  // data port
  input  logic          d_req,
  input  logic [31:0]   d_addr,
  input  logic [3:0]    d_we,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  // host loader port
  input  logic          ld_mode,
  input  logic          ld_req,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  // RAM port
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  // debug
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);

  state_t        state;
  logic [SW-1:0] streak;

  // ---------------------------------------------------------------------------
  // Grant selection (combinational from requests and registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    i_gnt  = 1'b0;
    d_gnt  = 1'b0;
    ld_gnt = 1'b0;
    case (state)
      RUN: begin
        // A rising ld_mode blocks cpu grants at once, so nothing new is
        // started while the bus is being handed over.
        if (!ld_mode) begin
          if (d_req && i_req) begin
            if (streak == STREAK_TOP) i_gnt = 1'b1;
            else                      d_gnt = 1'b1;
          end else if (d_req) begin
            d_gnt = 1'b1;
          end else if (i_req) begin
            i_gnt = 1'b1;
          end
        end
      end
      LOAD: begin
        // The cycle in which ld_mode drops is a pure transition cycle.
        ld_gnt = ld_req && ld_mode;
      end
      default: begin
        // DRAIN: no grants while the last cpu read retires.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM port mux: mirrors whichever requester was granted
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_we    = 4'h0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = ld_addr[AW+1:2];
      mem_we    = 4'hF;
      mem_wdata = ld_wdata;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = d_addr[AW+1:2];
      mem_we    = d_we;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = i_addr[AW+1:2];
    end
  end

  // Both read ports see the RAM output; rvalid says whose data it is.
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign dbg_state = state;

  // Byte-offset bits and bits above the RAM range are deliberately dropped:
  // addresses wrap modulo the RAM size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0],
                              d_addr[31:AW+2], d_addr[1:0],
                              ld_addr[31:AW+2], ld_addr[1:0]};

  // ---------------------------------------------------------------------------
  // State machine, streak counter and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      streak   <= '0;
      cpu_halt <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      i_rvalid <= i_gnt;
      d_rvalid <= d_gnt && (d_we == 4'h0);

      // The streak only measures how long a waiting instruction fetch has
      // been passed over. It clears as soon as nobody is waiting or the
      // fetch wins.
      if (!i_req || i_gnt) begin
        streak <= '0;
      end else if (d_gnt && (streak != STREAK_TOP)) begin
        streak <= streak + 1'b1;
      end

      case (state)
        RUN: begin
          if (ld_mode) begin
            state    <= DRAIN;
            cpu_halt <= 1'b1;
          end
        end
        DRAIN: begin
          // Single cycle, unconditional: the host has already been promised
          // the RAM once ld_mode was seen.
          state <= LOAD;
        end
        LOAD: begin
          if (!ld_mode) begin
            state    <= RUN;
            cpu_halt <= 1'b0;
            streak   <= '0;
          end
        end
        default: begin
          state    <= RUN;
          cpu_halt <= 1'b0;
        end
      endcase
    end
  end

endmodule
